// File: rtl/l1_mem_arb_if.sv
// Bundle of L1 request/ack and memory-bus signals shared by the arbiter and its neighbours.
// master = caches + memory (environment side), slave = the arbiter.
interface l1_mem_arb_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 128
);
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_ack;
    logic [LINE_W-1:0] ic_ack_data;
    logic              ic_ack_fault;

    logic              dc_req;
    logic [ADDR_W-1:0] dc_addr;
    logic              dc_rd;
    logic              dc_wr;
    logic [LINE_W-1:0] dc_wr_data;
    logic              dc_ack;
    logic [LINE_W-1:0] dc_ack_data;
    logic              dc_ack_fault;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [LINE_W-1:0] mem_wr_data;
    logic              mem_ack;
    logic [LINE_W-1:0] mem_ack_data;
    logic              mem_ack_fault;

    modport master (
        output ic_req, ic_addr,
        output dc_req, dc_addr, dc_rd, dc_wr, dc_wr_data,
        output mem_ack, mem_ack_data, mem_ack_fault,
        input  ic_ack, ic_ack_data, ic_ack_fault,
        input  dc_ack, dc_ack_data, dc_ack_fault,
        input  mem_req, mem_addr, mem_rd, mem_wr, mem_wr_data
    );

    modport slave (
        input  ic_req, ic_addr,
        input  dc_req, dc_addr, dc_rd, dc_wr, dc_wr_data,
        input  mem_ack, mem_ack_data, mem_ack_fault,
        output ic_ack, ic_ack_data, ic_ack_fault,
        output dc_ack, dc_ack_data, dc_ack_fault,
        output mem_req, mem_addr, mem_rd, mem_wr, mem_wr_data
    );
endinterface

// File: rtl/l1_mem_arb.sv
// Serialises I$ and D$ line misses onto one registered memory port with a response watchdog.
// Define ARB_RR_EN for round-robin on simultaneous requests; default is D$ fixed priority.
module l1_mem_arb #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 128,
    parameter int unsigned TO_CYC = 255
) (
    input logic          clk_in,
    input logic          reset_in,
    l1_mem_arb_if.slave  bus
);

    localparam logic [9:0] TO_LAST = 10'(TO_CYC - 1);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;
    typedef enum logic {OwnIc = 1'b0, OwnDc = 1'b1} owner_e;

    state_e            state_q, state_d;
    owner_e            gnt_q, last_q, win;
    logic [9:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              rd_q, wr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] ack_data_q;
    logic              ack_fault_q;

    logic any_req, dc_illegal, timeout;
    logic ack_ic, ack_dc;

    assign any_req    = bus.ic_req | bus.dc_req;
    assign dc_illegal = (bus.dc_rd == bus.dc_wr);
    assign timeout    = (cnt_q == TO_LAST);

    always_comb begin
        win = OwnIc;
        if (bus.ic_req && bus.dc_req) begin
`ifdef ARB_RR_EN
            win = (last_q == OwnIc) ? OwnDc : OwnIc;
`else
            win = OwnDc;
`endif
        end else if (bus.dc_req) begin
            win = OwnDc;
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (any_req) begin
                    // A malformed D$ command never reaches the bus; it is faulted directly.
                    state_d = (win == OwnDc && dc_illegal) ? StDone : StWait;
                end
            end
            StWait: begin
                if (bus.mem_ack || timeout) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ack_ic = (state_q == StDone) && (gnt_q == OwnIc);
        ack_dc = (state_q == StDone) && (gnt_q == OwnDc);

        bus.mem_req     = (state_q == StWait);
        bus.mem_addr    = addr_q;
        bus.mem_rd      = rd_q;
        bus.mem_wr      = wr_q;
        bus.mem_wr_data = wdata_q;

        bus.ic_ack       = ack_ic;
        bus.ic_ack_data  = ack_ic ? ack_data_q : '0;
        bus.ic_ack_fault = ack_ic & ack_fault_q;
        bus.dc_ack       = ack_dc;
        bus.dc_ack_data  = ack_dc ? ack_data_q : '0;
        bus.dc_ack_fault = ack_dc & ack_fault_q;
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            gnt_q       <= OwnIc;
            last_q      <= OwnIc;
            cnt_q       <= '0;
            addr_q      <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            ack_data_q  <= '0;
            ack_fault_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (any_req) begin
                        gnt_q <= win;
                        cnt_q <= '0;
                        if (win == OwnIc) begin
                            addr_q  <= bus.ic_addr;
                            rd_q    <= 1'b1;
                            wr_q    <= 1'b0;
                            wdata_q <= '0;
                        end else if (!dc_illegal) begin
                            addr_q  <= bus.dc_addr;
                            rd_q    <= bus.dc_rd;
                            wr_q    <= bus.dc_wr;
                            wdata_q <= bus.dc_wr_data;
                        end else begin
                            ack_data_q  <= '0;
                            ack_fault_q <= 1'b1;
                        end
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q + 10'd1;
                    // mem_ack takes precedence over a watchdog expiry in the same cycle.
                    if (bus.mem_ack) begin
                        ack_data_q  <= bus.mem_ack_data;
                        ack_fault_q <= bus.mem_ack_fault;
                    end else if (timeout) begin
                        ack_data_q  <= '0;
                        ack_fault_q <= 1'b1;
                    end
                end
                StDone: begin
                    last_q <= gnt_q;
                end
                default: ;
            endcase
        end
    end

    ack_onehot_a: assert property (@(posedge clk_in) disable iff (reset_in)
        !(bus.ic_ack && bus.dc_ack));

    mem_stable_a: assert property (@(posedge clk_in) disable iff (reset_in)
        bus.mem_req |=> (!bus.mem_req || ($stable(bus.mem_addr) && $stable(bus.mem_rd)
                                          && $stable(bus.mem_wr))));

endmodule

// File: doc/l1_mem_arb.md
# l1_mem_arb

Two-port arbiter sharing one external memory bus between the L1 instruction-cache miss path and the L1 data-cache miss/write-back path. It sits between the L1 caches and the system memory interface. It accepts a req/ack transaction from each cache and serializes them onto a single registered memory port. Each transaction is guarded by a response-timeout watchdog, and the result is routed back to the owning cache as a one-cycle ack.

## Interface
- ADDR_W, 32, address width (PC_SZ)
- LINE_W, 128, cache-line data width (CL_LEN*8)
- TO_CYC, 255, max cycles to wait for mem_ack before fault; range 1..1023
- clk_in  input  1  single clock; all logic on rising edge
- reset_in  input  1  reset, asynchronous, active-high
- ic_req  input  1  I$ request; held high with stable ic_addr until ic_ack
- ic_addr  input  ADDR_W  I$ line address
- ic_ack  output  1  one-cycle completion pulse to I$
- ic_ack_data  output  LINE_W  read line; valid only while ic_ack=1
- ic_ack_fault  output  1  fault flag; valid only while ic_ack=1
- dc_req  input  1  D$ request; held high with stable dc_* until dc_ack
- dc_addr  input  ADDR_W  D$ line address
- dc_rd  input  1  D$ line read
- dc_wr  input  1  D$ line write
- dc_wr_data  input  LINE_W  write line
- dc_ack, dc_ack_data, dc_ack_fault  output  1/LINE_W/1  as the I$ equivalents
- mem_req  output  1  memory request, registered
- mem_addr  output  ADDR_W  registered address
- mem_rd, mem_wr  output  1  registered direction
- mem_wr_data  output  LINE_W  registered write line
- mem_ack  input  1  memory completion pulse
- mem_ack_data  input  LINE_W  read data, valid with mem_ack
- mem_ack_fault  input  1  memory fault, valid with mem_ack

## Operation
- **FSM states:** IDLE, WAIT, DONE.
- **Grant register:** gnt (IC/DC) records the current owner.
- **Last-winner register:** last tracks the most recent winner for arbitration.
- **IDLE:**
  - If no req is high: stay in IDLE.
  - Otherwise pick a winner (see Configuration). For an I$ win, load mem_addr=ic_addr, mem_rd=1, mem_wr=0. For a D$ win, load from dc_*.
  - Then set mem_req=1, clear the timeout counter and go to WAIT.
- **Illegal D$ command:** if the D$ wins with dc_rd==dc_wr (both 0 or both 1), no mem_req is issued. The arbiter goes directly to DONE with ack_fault=1 and ack_data=0.
- **WAIT:** mem_req stays high and the counter increments every cycle.
  - On mem_ack=1: capture mem_ack_data and mem_ack_fault into the owner's ack registers, drop mem_req and go to DONE.
  - On counter==TO_CYC-1 without mem_ack: drop mem_req, set owner ack_fault=1 and ack_data=0, and go to DONE. Dropping mem_req is an abort; the memory side must discard the request.
- **DONE:** the owner's ack is high for exactly this one cycle. Update last=gnt, then go to IDLE.
- **Requester protocol:** the requester deasserts req, or presents a new request, in the cycle after it sees ack. A req that is high in IDLE is always treated as a new request.
- **Ignored inputs:** mem_ack outside WAIT is ignored. This includes a late ack after a timeout.
- **Counter width:** 10 bits, so no wrap for the legal TO_CYC range.

## Timing
- **Reset:** all outputs are 0, state=IDLE, counter=0, last=IC, gnt=IC.
- **Issue latency:** req sampled high in IDLE at cycle N gives mem_req=1 at N+1.
- **Completion latency:** mem_ack at cycle M gives owner ack=1 at M+1 and mem_req=0 at M+1. The arbiter is back in IDLE at M+2.
- **Minimum transaction:** 3 cycles from req to ack, with a zero-wait memory.
- **Timeout:** with mem_req first high at N+1 and no mem_ack, mem_req falls at N+1+TO_CYC, and ack+fault is seen in that same cycle.
- **Illegal D$ command:** request sampled at N gives dc_ack with fault at N+1, and mem_req never rises.
- **mem_ack in the final WAIT cycle:** if mem_ack arrives in the same cycle the counter hits TO_CYC-1, the ack wins and the fault comes from mem_ack_fault.
- **Output stability:** the mem_* outputs are stable from mem_req rise until it falls.
- **Reset mid-transaction:** everything clears immediately. No ack is produced for the aborted request.

## Configuration
- **Macro:** ARB_RR_EN.
- **Defined:** round-robin. On simultaneous ic_req and dc_req in IDLE, the requester not equal to last wins. A single requester always wins.
- **Undefined:** fixed priority, D$ always wins ties. The last register is still maintained but unused.

## Test plan
- **Single I$ read:** ic_req=1, ic_addr=0x0000_1000, memory acks after 2 cycles with data 0x0123…CDEF. Expect mem_req=1, mem_rd=1, mem_addr=0x1000 for 3 cycles, then ic_ack one cycle later with the data and fault=0, and dc_ack=0 throughout.
- **Simultaneous requests, ARB_RR_EN defined:** both reqs held continuously from reset. Expect grant order DC, IC, DC, IC.
- **Simultaneous requests, ARB_RR_EN undefined:** same stimulus. Expect DC granted every time while dc_req stays high.
- **Timeout:** TO_CYC=4, dc_wr to 0x2000 and memory never acks. Expect mem_req high exactly 4 cycles, then dc_ack=1, dc_ack_fault=1, dc_ack_data=0. A mem_ack injected 2 cycles later produces no ack.
- **Illegal D$ command:** dc_rd=1, dc_wr=1. Expect dc_ack with fault the cycle after sampling and mem_req=0 throughout.
- **Reset mid-transaction:** assert reset_in in WAIT while mem_req=1. Expect all outputs 0 immediately, no ack after release, and a new ic_req served normally.
